// File: rtl/ps2_key_decoder_if.sv
// Key-event stream from the PS/2 decoder FIFO head to a keycode consumer.
// A pop happens on any clock edge where key_valid and key_ready are both high.
interface ps2_key_decoder_if;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_data;
    logic       key_broken;
    logic [3:0] key_mods;

    modport master (
        output key_valid,
        output key_data,
        output key_broken,
        output key_mods,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_data,
        input  key_broken,
        input  key_mods,
        output key_ready
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code-set-2 decoder: prefix FSM, modifier tracking, sequence timeout
// and a first-word-fall-through key-event FIFO with a valid/ready head.
module ps2_key_decoder #(
    parameter int         FIFO_DEPTH     = 8,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] PAUSE_CODE     = 8'h41
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ps2_rx_stb,
    input  logic [7:0]                  ps2_rx_data,
    ps2_key_decoder_if.master           key,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]     DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    localparam int M_LSHIFT = 0;
    localparam int M_RSHIFT = 1;
    localparam int M_LCTRL  = 2;
    localparam int M_RCTRL  = 3;
    localparam int M_LALT   = 4;
    localparam int M_RALT   = 5;
    localparam int M_LWIN   = 6;
    localparam int M_RWIN   = 7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK,
        PAUSE
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      skip_cnt, skip_nx;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    logic [7:0]      mod_state, mods_nx;

    logic            dec_go, dec_ext, dec_brk, pause_go;
    logic [7:0]      dec_code, dec_mask;

    logic            ev_valid, ev_valid_nx;
    logic [7:0]      ev_code, ev_code_nx;
    logic            ev_broken, ev_broken_nx;
    logic [3:0]      ev_mods, ev_mods_nx;

    logic [12:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [12:0]     last_word, head_word;
    logic            full, pop, push_ok, drop;

    function automatic logic [7:0] map_base(input logic [7:0] sc);
        case (sc)
            8'h1C: map_base = 8'h01;
            8'h32: map_base = 8'h02;
            8'h21: map_base = 8'h03;
            8'h23: map_base = 8'h04;
            8'h24: map_base = 8'h05;
            8'h2B: map_base = 8'h06;
            8'h34: map_base = 8'h07;
            8'h33: map_base = 8'h08;
            8'h43: map_base = 8'h09;
            8'h3B: map_base = 8'h0A;
            8'h42: map_base = 8'h0B;
            8'h4B: map_base = 8'h0C;
            8'h3A: map_base = 8'h0D;
            8'h31: map_base = 8'h0E;
            8'h44: map_base = 8'h0F;
            8'h4D: map_base = 8'h10;
            8'h15: map_base = 8'h11;
            8'h2D: map_base = 8'h12;
            8'h1B: map_base = 8'h13;
            8'h2C: map_base = 8'h14;
            8'h3C: map_base = 8'h15;
            8'h2A: map_base = 8'h16;
            8'h1D: map_base = 8'h17;
            8'h22: map_base = 8'h18;
            8'h35: map_base = 8'h19;
            8'h1A: map_base = 8'h1A;
            8'h45: map_base = 8'h1B;
            8'h16: map_base = 8'h1C;
            8'h1E: map_base = 8'h1D;
            8'h26: map_base = 8'h1E;
            8'h25: map_base = 8'h1F;
            8'h2E: map_base = 8'h20;
            8'h36: map_base = 8'h21;
            8'h3D: map_base = 8'h22;
            8'h3E: map_base = 8'h23;
            8'h46: map_base = 8'h24;
            8'h29: map_base = 8'h25;
            8'h66: map_base = 8'h26;
            8'h0D: map_base = 8'h27;
            8'h76: map_base = 8'h28;
            8'h0E: map_base = 8'h29;
            8'h4E: map_base = 8'h2A;
            8'h55: map_base = 8'h2B;
            8'h54: map_base = 8'h2C;
            8'h12: map_base = 8'h2D;
            8'h59: map_base = 8'h2D;
            8'h14: map_base = 8'h2E;
            8'h11: map_base = 8'h2F;
            8'h5A: map_base = 8'h30;
            8'h58: map_base = 8'h31;
            8'h5B: map_base = 8'h33;
            8'h5D: map_base = 8'h34;
            8'h4C: map_base = 8'h35;
            8'h52: map_base = 8'h36;
            8'h41: map_base = 8'h37;
            8'h49: map_base = 8'h38;
            8'h4A: map_base = 8'h39;
            8'h05: map_base = 8'h3A;
            8'h06: map_base = 8'h3B;
            8'h04: map_base = 8'h3C;
            8'h0C: map_base = 8'h3D;
            8'h03: map_base = 8'h3E;
            8'h0B: map_base = 8'h3F;
            8'h83: map_base = 8'h40;
            8'h0A: map_base = 8'h42;
            8'h01: map_base = 8'h43;
            8'h09: map_base = 8'h44;
            8'h78: map_base = 8'h45;
            8'h07: map_base = 8'h46;
            default: map_base = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] map_ext(input logic [7:0] sc);
        case (sc)
            8'h5A: map_ext = 8'h30;
            8'h75: map_ext = 8'h47;
            8'h72: map_ext = 8'h48;
            8'h6B: map_ext = 8'h49;
            8'h74: map_ext = 8'h4A;
            8'h70: map_ext = 8'h4B;
            8'h71: map_ext = 8'h4C;
            8'h6C: map_ext = 8'h4D;
            8'h69: map_ext = 8'h4E;
            8'h7D: map_ext = 8'h4F;
            8'h7A: map_ext = 8'h50;
            8'h4A: map_ext = 8'h39;
            8'h14: map_ext = 8'h2E;
            8'h11: map_ext = 8'h2F;
            8'h1F: map_ext = 8'h32;
            8'h27: map_ext = 8'h32;
            default: map_ext = 8'h00;
        endcase
    endfunction

    // One-hot position of a modifier key in mod_state, zero for ordinary keys.
    function automatic logic [7:0] mod_mask(input logic ext, input logic [7:0] sc);
        mod_mask = 8'h00;
        if (!ext) begin
            case (sc)
                8'h12:   mod_mask[M_LSHIFT] = 1'b1;
                8'h59:   mod_mask[M_RSHIFT] = 1'b1;
                8'h14:   mod_mask[M_LCTRL]  = 1'b1;
                8'h11:   mod_mask[M_LALT]   = 1'b1;
                default: mod_mask = 8'h00;
            endcase
        end else begin
            case (sc)
                8'h14:   mod_mask[M_RCTRL]  = 1'b1;
                8'h11:   mod_mask[M_RALT]   = 1'b1;
                8'h1F:   mod_mask[M_LWIN]   = 1'b1;
                8'h27:   mod_mask[M_RWIN]   = 1'b1;
                default: mod_mask = 8'h00;
            endcase
        end
    endfunction

    function automatic logic [3:0] fold_mods(input logic [7:0] m);
        fold_mods = {m[M_LWIN]  | m[M_RWIN],
                     m[M_LALT]  | m[M_RALT],
                     m[M_LCTRL] | m[M_RCTRL],
                     m[M_LSHIFT]| m[M_RSHIFT]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            tmo_cnt   <= '0;
            mod_state <= '0;
            ev_valid  <= 1'b0;
            ev_code   <= '0;
            ev_broken <= 1'b0;
            ev_mods   <= '0;
        end else begin
            state     <= state_nx;
            skip_cnt  <= skip_nx;
            tmo_cnt   <= tmo_nx;
            mod_state <= mods_nx;
            ev_valid  <= ev_valid_nx;
            ev_code   <= ev_code_nx;
            ev_broken <= ev_broken_nx;
            ev_mods   <= ev_mods_nx;
        end
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        tmo_nx   = tmo_cnt;
        mods_nx  = mod_state;
        dec_go   = 1'b0;
        dec_ext  = 1'b0;
        dec_brk  = 1'b0;
        pause_go = 1'b0;

        if (ps2_rx_stb) begin
            tmo_nx = '0;
            case (state)
                IDLE: begin
                    case (ps2_rx_data)
                        8'hE0: state_nx = EXT;
                        8'hF0: state_nx = BRK;
                        8'hE1: begin
                            state_nx = PAUSE;
                            skip_nx  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_nx = IDLE;
                        default: dec_go = 1'b1;
                    endcase
                end
                EXT: begin
                    if (ps2_rx_data == 8'hF0) begin
                        state_nx = EXTBRK;
                    end else if (ps2_rx_data != 8'hE0 && ps2_rx_data != 8'h12) begin
                        dec_go   = 1'b1;
                        dec_ext  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    dec_go   = 1'b1;
                    dec_brk  = 1'b1;
                    state_nx = IDLE;
                end
                EXTBRK: begin
                    state_nx = IDLE;
                    if (ps2_rx_data != 8'h12) begin
                        dec_go  = 1'b1;
                        dec_ext = 1'b1;
                        dec_brk = 1'b1;
                    end
                end
                PAUSE: begin
                    if (skip_cnt == 3'd1) begin
                        pause_go = 1'b1;
                        skip_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        skip_nx = skip_cnt - 3'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && TIMEOUT_CYCLES != 0) begin
            // An abandoned partial sequence falls back to IDLE without an event.
            if (tmo_cnt == TMO_LAST) begin
                state_nx = IDLE;
                skip_nx  = '0;
                tmo_nx   = '0;
            end else begin
                tmo_nx = tmo_cnt + 1'b1;
            end
        end else begin
            tmo_nx = '0;
        end

        dec_code = dec_ext ? map_ext(ps2_rx_data) : map_base(ps2_rx_data);
        dec_mask = mod_mask(dec_ext, ps2_rx_data);
        if (dec_go) begin
            mods_nx = dec_brk ? (mod_state & ~dec_mask) : (mod_state | dec_mask);
        end

        ev_valid_nx  = (dec_go && dec_code != 8'h00) || pause_go;
        ev_code_nx   = pause_go ? PAUSE_CODE : dec_code;
        ev_broken_nx = dec_go && dec_brk;
        ev_mods_nx   = fold_mods(mods_nx);
    end

    always_comb begin
        full      = (count == DEPTH_C);
        pop       = (count != '0) && key.key_ready;
        push_ok   = ev_valid && (!full || pop);
        drop      = ev_valid && full && !pop;
        head_word = (count != '0) ? mem[rd_ptr] : last_word;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {ev_mods, ev_broken, ev_code};
        end
    end

    // last_word keeps the most recently popped entry visible while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_word <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_word <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign key.key_valid  = (count != '0);
    assign key.key_data   = head_word[7:0];
    assign key.key_broken = head_word[8];
    assign key.key_mods   = head_word[12:9];
    assign fifo_count     = count;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised PS/2 scan-code-set-2 decoder that replaces the buffer-matching converter with an explicit prefix state machine.
- Adds modifier-state tracking, a partial-sequence timeout and an output event FIFO with valid/ready handshake.
- Sits between ps2Listener (ps2_rx_stb/ps2_rx_data) and any keycode consumer (terminal, CPU port).

Parameters:
- FIFO_DEPTH, 8, key-event FIFO entries. Power of two, at least 2.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one sequence. 0 disables the timeout.
- PAUSE_CODE, 8'h41, keycode emitted for PAUSE/BREAK.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_rx_stb  in  1  one-cycle strobe: new byte on ps2_rx_data.
- ps2_rx_data  in  8  received scan-code byte.
- key_valid  out  1  FIFO head holds an event.
- key_ready  in  1  consumer accepts the head. A pop occurs when key_valid && key_ready.
- key_data  out  8  head keycode. 0x00 never emitted.
- key_broken  out  1  head is a release event.
- key_mods  out  4  modifier state after the head event: {win, alt, ctrl, shift}.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, all modifiers released, timeout counter=0.
  - Outputs at reset: key_valid=0, key_data=0, key_broken=0, key_mods=0, overflow=0, fifo_count=0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen), PAUSE (E1 seen). FSM advances only on ps2_rx_stb.
  - IDLE: E0->EXT, F0->BRK, E1->PAUSE (skip count=7). Bytes AA, FA, FE, EE, 00, FF are ignored, stay IDLE. Any other byte: decode as make, non-extended, ->IDLE.
  - EXT: F0->EXTBRK. E0 and 12 (fake shift) stay in EXT. Other byte: decode as extended make, ->IDLE.
  - BRK: byte decoded as non-extended break, ->IDLE.
  - EXTBRK: 12 (fake shift) ->IDLE with no event. Other byte: decode as extended break, ->IDLE.
  - PAUSE: consume 7 further bytes. On the 7th, emit make event PAUSE_CODE, ->IDLE. No break event is ever emitted for PAUSE.
- Decode uses the team set-2 keycode table (non-extended and E0-extended maps). Anchors: 1C->01 (A), 5A->30, E0 5A->30, E0 75->47, 12->2D, 59->2D, 14->2E, 11->2F, E0 1F/E0 27->32. An unmapped byte produces no event and the FSM returns to IDLE.
- Modifiers: left and right are tracked separately internally: lshift, rshift, lctrl, rctrl (E0 14), lalt, ralt (E0 11), lwin, rwin.
  - Make sets the bit; break clears it.
  - key_mods bit = OR of its left/right pair, so releasing one side while the other is held keeps the bit at 1.
  - Modifier keys are also emitted as normal events.
  - Stored key_mods reflects the state after that event is applied.
- Latency: byte strobed at edge k -> FIFO write at edge k+1. If the FIFO was empty, key_valid=1 from edge k+1. Back-to-back strobes must be sustained.
- FIFO: first-word-fall-through. key_data/key_broken/key_mods stay stable while key_valid && !key_ready.
  - Full and no pop: the new event is dropped, overflow set.
  - Full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Empty: key_valid=0, outputs hold the last popped values.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set has priority over overflow_clr in the same cycle.
- Timeout: counter clears on every strobe and counts while FSM != IDLE. At TIMEOUT_CYCLES: FSM->IDLE, skip count cleared, no event, modifiers unchanged. In IDLE the counter is held at 0.
- Async reset mid-sequence or with the FIFO non-empty discards everything. The first byte after release is treated as IDLE input.

Test Plan:
1. Bytes 1C, F0 1C with key_ready=1 -> events {01, broken=0, mods=0} then {01, broken=1, mods=0}. Each key_valid appears 1 cycle after its final strobe.
2. Bytes 12, 59, F0 12, 1C -> A event carries mods=4'b0001 (RSHIFT still held). Then F0 59, 1C -> mods=0.
3. Bytes E0 F0 75 -> {47, broken=1}. Bytes E0 12 E0 75 -> a single {47, broken=0}; the fake shift produces no event.
4. Full PAUSE sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {PAUSE_CODE, broken=0}; mods unchanged.
5. key_ready=0, FIFO_DEPTH+2 make events -> fifo_count=FIFO_DEPTH, overflow=1, first FIFO_DEPTH events drain in order. Push with simultaneous pop when full -> accepted. overflow_clr -> overflow=0.
6. TIMEOUT_CYCLES=16: byte E0, idle 16 cycles, then 1C -> event {01, non-extended, make}. Assert rst_n=0 with 3 entries queued -> key_valid=0 and fifo_count=0 immediately (asynchronously).
